// File: rtl/c_buf.sv
// Router input-channel buffer: small FIFO of flits, each head flit offering two
// independently consumed tokens (flit on out, route bit on req).
module c_buf #(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROUTE_BIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             req_valid,
  output logic             req_data,
  input  logic             req_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_done_q, out_done_d;
  logic             req_done_q, req_done_d;

  logic             not_empty;
  logic             push, pop;
  logic             out_fin, req_fin;

  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q != CW'(DEPTH)) & ~reset;
    out_valid = not_empty & ~out_done_q;
    req_valid = not_empty & ~req_done_q;
    out_data  = mem_q[rd_ptr_q];
    req_data  = mem_q[rd_ptr_q][ROUTE_BIT];

    // A token counts as finished if it was taken earlier or is taken this cycle.
    out_fin = out_done_q | (out_valid & out_ready);
    req_fin = req_done_q | (req_valid & req_ready);
    pop     = not_empty & out_fin & req_fin;
    push    = in_valid & in_ready;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_done_d = pop ? 1'b0 : out_fin;
    req_done_d = pop ? 1'b0 : req_fin;
    count_d    = count_q + CW'(push) - CW'(pop);

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_done_q <= 1'b0;
      req_done_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_done_q <= out_done_d;
      req_done_q <= req_done_d;
    end
  end

endmodule

// File: tb/tb_c_buf.sv
// Directed bench for c_buf with a per-cycle scoreboard model of FIFO occupancy
// and per-token completion.
module tb_c_buf;

  localparam int unsigned WIDTH     = 11;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ROUTE_BIT = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             req_valid;
  logic             req_data;
  logic             req_ready;

  int checks = 0;
  int errors = 0;

  c_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROUTE_BIT(ROUTE_BIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected head flits queued when accepted, compared while presented.
  logic [WIDTH-1:0] exp_q [$];
  int               m_count = 0;
  logic             m_odone = 1'b0;
  logic             m_rdone = 1'b0;

  always @(negedge clk) begin
    logic             e_ir, e_ov, e_rv, ofin, rfin, mpush, mpop;
    logic [WIDTH-1:0] head;
    if (reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_req_data", req_data, 0);
      exp_q.delete();
      m_count = 0;
      m_odone = 1'b0;
      m_rdone = 1'b0;
    end else begin
      e_ir = (m_count != DEPTH);
      e_ov = (m_count != 0) && !m_odone;
      e_rv = (m_count != 0) && !m_rdone;
      check("in_ready", in_ready, e_ir);
      check("out_valid", out_valid, e_ov);
      check("req_valid", req_valid, e_rv);
      if (m_count != 0) begin
        head = exp_q[0];
        if (e_ov) check("out_data", out_data, head);
        if (e_rv) check("req_data", req_data, head[ROUTE_BIT]);
      end
      ofin  = m_odone || (e_ov && out_ready);
      rfin  = m_rdone || (e_rv && req_ready);
      mpop  = (m_count != 0) && ofin && rfin;
      mpush = in_valid && e_ir;
      if (mpop) begin
        void'(exp_q.pop_front());
        m_odone = 1'b0;
        m_rdone = 1'b0;
        m_count--;
      end else begin
        m_odone = ofin;
        m_rdone = rfin;
      end
      if (mpush) begin
        exp_q.push_back(in_data);
        m_count++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 40) begin
      step(1);
      t++;
    end
    check("push_timeout", (t < 40), 1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while ((out_valid || req_valid) && t < 60) begin
      step(1);
      t++;
    end
    check("drain_timeout", (t < 60), 1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; req_ready = 1'b0;
    step(2);
    check("reset_out_data", out_data, 0);
    reset = 1'b0;
    step(1);
    check("post_reset_in_ready", in_ready, 1);

    // 1: both tokens taken in the same cycle
    push_one(11'b01010100100);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 11'h2A4);
    check("t1_req_data", req_data, 0);
    out_ready = 1'b1; req_ready = 1'b1;
    step(1);
    out_ready = 1'b0; req_ready = 1'b0;
    check("t1_empty", out_valid | req_valid, 0);

    // 2: out first, req three cycles later
    push_one(11'b00001100111);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t2_out_dropped", out_valid, 0);
    check("t2_req_held", req_valid, 1);
    check("t2_req_data", req_data, 1);
    step(2);
    check("t2_req_still", req_valid, 1);
    req_ready = 1'b1;
    step(1);
    req_ready = 1'b0;
    check("t2_popped", out_valid | req_valid, 0);

    // 3: req first, then out
    push_one(11'b11111100101);
    check("t3_req_data", req_data, 1);
    req_ready = 1'b1;
    step(1);
    req_ready = 1'b0;
    check("t3_req_gone", req_valid, 0);
    step(2);
    check("t3_out_held", out_valid, 1);
    check("t3_out_data", out_data, 11'h7E5);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t3_popped", out_valid, 0);

    // 4: readies low, fill to full, fifth flit held off, drain in order
    push_one(11'b01111000110);
    step(3);
    check("t4_out_valid", out_valid, 1);
    check("t4_req_valid", req_valid, 1);
    check("t4_req_data", req_data, 0);
    for (int i = 0; i < 3; i++) push_one(WIDTH'(11'h100 + i));
    check("t4_full", in_ready, 0);
    in_valid = 1'b1; in_data = 11'h103;
    step(3);
    check("t4_held", in_ready, 0);
    check("t4_head_kept", out_data, 11'h3C6);
    out_ready = 1'b1; req_ready = 1'b1;
    push_one(11'h103);
    push_one(11'h104);
    wait_empty();
    out_ready = 1'b0; req_ready = 1'b0;

    // 5: streaming at one flit per cycle across pointer wrap
    out_ready = 1'b1; req_ready = 1'b1;
    cyc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = WIDTH'(11'h2F0 + 3 * i);
      if (in_ready) cyc++;
      step(1);
    end
    in_valid = 1'b0;
    check("t5_throughput", cyc, 10);
    step(2);
    check("t5_empty", out_valid, 0);
    out_ready = 1'b0; req_ready = 1'b0;

    // 6: reset with two flits stored and the head's out token already taken
    push_one(11'h155);
    push_one(11'h0AA);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t6_out_done", out_valid, 0);
    check("t6_req_pending", req_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_req_valid", req_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    step(2);
    reset = 1'b0;
    out_ready = 1'b1; req_ready = 1'b1;
    step(5);
    check("t6_no_stale", out_valid | req_valid, 0);
    check("t6_in_ready", in_ready, 1);
    out_ready = 1'b0; req_ready = 1'b0;
    step(1);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
